sim_sequencer: RTL and testbench
================================

SIM_SEQUENCER -- requirements
Module: sim_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, 32, Q16.16 velocity word width.
REQ-002 Parameter INPUT_WIDTH, 8, pilot pitch/roll width; throttle is INPUT_WIDTH+1.
REQ-003 Parameter TICK_DIV, 833333, clk cycles per simulation tick (60 Hz at 50 MHz).
REQ-004 Parameter TIMEOUT, 1024, maximum clk cycles one update may take.
REQ-005 clk  in  1  system clock; one clock domain only.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 run  in  1  level; enables periodic ticking.
REQ-008 step  in  1  single-cycle pulse; one manual update when run=0.
REQ-009 clear_err  in  1  single-cycle pulse; clears the sticky error flags.
REQ-010 pitch_in, roll_in  in  INPUT_WIDTH signed  live pilot rates, deg/s.
REQ-011 throttle_in  in  INPUT_WIDTH+1  live throttle, 0-100.
REQ-012 update_enable  out  1  starts a plane_state update.
REQ-013 update_done  in  1  plane_state update complete.
REQ-014 request_input / input_ready  in / out  1  input handshake with plane_state.
REQ-015 pitch_change, roll_change, throttle  out  as inputs  registered snapshot of pilot inputs.
REQ-016 request_velocities / velocities_ready  in / out  1  velocity handshake with plane_state.
REQ-017 vel_req / vel_ack  out / in  1  handshake with the velocity engine.
REQ-018 vel_x_in, vel_y_in, vel_z_in  in  DATA_WIDTH signed  engine velocities.
REQ-019 v_x, v_y, v_z  out  DATA_WIDTH signed  registered velocities to plane_state.
REQ-020 frame_count  out  16  count of completed updates.
REQ-021 busy, overrun, timeout_err  out  1  update in progress, sticky dropped-tick flag, sticky timeout flag.

Function
REQ-022 Tick: while run=1, the divider counts 0..TICK_DIV-1 and the tick pulses for one cycle on the wrap; while run=0, the divider is held at 0.
REQ-023 FSM states and transitions: IDLE -> UPDATE on (tick, or step with run=0); UPDATE -> IDLE on update_done or on timeout.
REQ-024 In UPDATE: update_enable=1 and busy=1, both asserted the cycle after entry; both are 0 in IDLE.
REQ-025 A tick or step outside IDLE is dropped, not queued; a dropped tick sets overrun; step while busy or while run=1 is ignored without any flag.
REQ-026 Input handshake: the first cycle request_input=1 with input_ready=0 latches pitch_in, roll_in and throttle_in; input_ready=1 the following cycle and is held while request_input=1; input_ready=0 the cycle after request_input falls.
REQ-027 Velocity handshake: request_velocities=1 raises vel_req the next cycle; vel_req is held until vel_ack=1.
REQ-028 On the vel_ack cycle, vel_x/y/z_in are latched into v_x/y/z and vel_req drops; velocities_ready=1 the next cycle, held while request_velocities=1.
REQ-029 Handshakes are serviced only in UPDATE; requests arriving in IDLE are ignored.
REQ-030 Timeout: a cycle counter runs in UPDATE; reaching TIMEOUT without update_done sets timeout_err and returns to IDLE.
REQ-031 On timeout, all ready/req outputs drop and frame_count is not incremented.
REQ-032 update_done and timeout in the same cycle: done wins; no error is set.
REQ-033 Each update_done in UPDATE increments frame_count modulo 2^16 (0xFFFF -> 0x0000).
REQ-034 clear_err clears overrun and timeout_err; a set event in the same cycle wins.

Reset
REQ-035 Reset is asynchronous and active-high, effective on assertion regardless of clk.
REQ-036 Reset state: FSM in IDLE; divider, timeout counter and frame_count = 0.
REQ-037 Reset state: all 1-bit outputs = 0; v_x/y/z, pitch_change, roll_change and throttle = 0.
REQ-038 Reset mid-update abandons the handshake with no completion side effects.

Structure
REQ-039 The FSM state encoding and the DATA_WIDTH/INPUT_WIDTH constants live in the shared flight package.
REQ-040 One sub-module, tick_divider (parameter TICK_DIV; ports enable, tick), is natural.

Verification
REQ-041 TICK_DIV=10, run=1, update_done 3 cycles after update_enable -> ticks every 10 cycles; frame_count steps 0,1,2; overrun stays 0.
REQ-042 Set pitch_in=-5, then raise request_input -> input_ready high one cycle later; pitch_change=0xFB, unchanged after pitch_in changes while request_input is held.
REQ-043 request_velocities with vel_ack delayed 4 cycles, vel_y_in=0xFFFF0000 -> velocities_ready high one cycle after ack; v_y=0xFFFF0000.
REQ-044 TIMEOUT=16, update_done never asserted -> timeout_err=1 at entry+16 and FSM back in IDLE; clear_err -> timeout_err=0.
REQ-045 TICK_DIV=4, update held 6 cycles -> overrun=1 and exactly one tick dropped; frame_count=0xFFFF plus one more done -> frame_count=0x0000.
REQ-046 Reset asserted mid-UPDATE between clk edges -> all outputs zero immediately; after release, step with run=0 runs one update.

Source files
------------

// File: rtl/sim_sequencer_pkg.sv
// Shared flight definitions: word widths, the sequencer state encoding and a
// small helper for sizing counters from their terminal count.
package sim_sequencer_pkg;

  // Q16.16 velocity word and pilot pitch/roll width; throttle is one bit wider.
  localparam int FLIGHT_DATA_WIDTH  = 32;
  localparam int FLIGHT_INPUT_WIDTH = 8;
  localparam int FRAME_COUNT_WIDTH  = 16;

  typedef enum logic [0:0] {
    SEQ_IDLE   = 1'b0,
    SEQ_UPDATE = 1'b1
  } seq_state_e;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_sequencer_tick_divider.sv
// Simulation tick divider: counts clk cycles while enabled and pulses tick for
// one cycle every TICK_DIV cycles. Disabling parks the count at zero so the
// first tick after enabling always comes a full period later.
module sim_sequencer_tick_divider
  import sim_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  // Free-running period counter, wrapping on the tick cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sim_sequencer.sv
// Simulation sequencer: paces plane_state updates from the tick divider (run=1)
// or a manual step (run=0), services the pilot-input and velocity handshakes
// while an update is in flight, and keeps sticky flags for dropped ticks and
// stalled updates.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   SEQ_IDLE    | waiting for a tick, or a step while run=0
//   SEQ_UPDATE  | update in flight; handshakes serviced, timeout armed
module sim_sequencer
  import sim_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = FLIGHT_DATA_WIDTH,
  parameter int INPUT_WIDTH = FLIGHT_INPUT_WIDTH,
  parameter int TICK_DIV    = 833333,
  parameter int TIMEOUT     = 1024,
  parameter int FRAME_WIDTH = FRAME_COUNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          step,
  input  logic                          clear_err,
  input  logic signed [INPUT_WIDTH-1:0] pitch_in,
  input  logic signed [INPUT_WIDTH-1:0] roll_in,
  input  logic [INPUT_WIDTH:0]          throttle_in,
  output logic                          update_enable,
  input  logic                          update_done,
  input  logic                          request_input,
  output logic                          input_ready,
  output logic signed [INPUT_WIDTH-1:0] pitch_change,
  output logic signed [INPUT_WIDTH-1:0] roll_change,
  output logic [INPUT_WIDTH:0]          throttle,
  input  logic                          request_velocities,
  output logic                          velocities_ready,
  output logic                          vel_req,
  input  logic                          vel_ack,
  input  logic signed [DATA_WIDTH-1:0]  vel_x_in,
  input  logic signed [DATA_WIDTH-1:0]  vel_y_in,
  input  logic signed [DATA_WIDTH-1:0]  vel_z_in,
  output logic signed [DATA_WIDTH-1:0]  v_x,
  output logic signed [DATA_WIDTH-1:0]  v_y,
  output logic signed [DATA_WIDTH-1:0]  v_z,
  output logic [FRAME_WIDTH-1:0]        frame_count,
  output logic                          busy,
  output logic                          overrun,
  output logic                          timeout_err
);

  // The timeout timer is a down-counter loaded on entry; zero means this is
  // the last cycle the update is allowed to run.
  localparam int            TW      = cnt_width(TIMEOUT);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);

  seq_state_e    state;
  seq_state_e    state_nxt;
  logic          tick;
  logic          enter_update;
  logic          done_hit;
  logic          timeout_hit;
  logic          tick_drop;
  logic          hs_active;
  logic [TW-1:0] to_count;

  sim_sequencer_tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk    (clk),
    .reset  (reset),
    .enable (run),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEQ_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore outputs; done takes priority over an expiring timer.
  always_comb begin
    state_nxt     = state;
    update_enable = 1'b0;
    busy          = 1'b0;
    enter_update  = 1'b0;
    done_hit      = 1'b0;
    timeout_hit   = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (tick || (step && !run)) begin
          enter_update = 1'b1;
          state_nxt    = SEQ_UPDATE;
        end
      end
      SEQ_UPDATE: begin
        update_enable = 1'b1;
        busy          = 1'b1;
        done_hit      = update_done;
        timeout_hit   = !update_done && (to_count == '0);
        if (done_hit || timeout_hit) begin
          state_nxt = SEQ_IDLE;
        end
      end
      default: begin
        state_nxt = SEQ_IDLE;
      end
    endcase
  end

  // Handshakes only run while the update continues past this cycle, so any
  // exit (done or timeout) drops every ready/req output on the same edge.
  assign hs_active = (state == SEQ_UPDATE) && (state_nxt == SEQ_UPDATE);

  // A tick landing outside IDLE is lost rather than queued.
  assign tick_drop = tick && (state != SEQ_IDLE);

  // Update timeout down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_count <= '0;
    end else if (enter_update) begin
      to_count <= TO_LOAD;
    end else if ((state == SEQ_UPDATE) && (to_count != '0)) begin
      to_count <= to_count - 1'b1;
    end
  end

  // Completed-update counter, wrapping naturally at its width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (done_hit) begin
      frame_count <= frame_count + 1'b1;
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (tick_drop) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

  // Pilot input snapshot: capture once at the start of a request so the
  // values stay stable for as long as plane_state holds request_input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      input_ready  <= 1'b0;
      pitch_change <= '0;
      roll_change  <= '0;
      throttle     <= '0;
    end else if (!hs_active) begin
      input_ready <= 1'b0;
    end else if (request_input) begin
      if (!input_ready) begin
        pitch_change <= pitch_in;
        roll_change  <= roll_in;
        throttle     <= throttle_in;
      end
      input_ready <= 1'b1;
    end else begin
      input_ready <= 1'b0;
    end
  end

  // Velocity relay: forward the request to the engine, capture on ack, then
  // report ready until plane_state withdraws its request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vel_req          <= 1'b0;
      velocities_ready <= 1'b0;
      v_x              <= '0;
      v_y              <= '0;
      v_z              <= '0;
    end else if (!hs_active) begin
      vel_req          <= 1'b0;
      velocities_ready <= 1'b0;
    end else if (vel_req) begin
      if (vel_ack) begin
        v_x              <= vel_x_in;
        v_y              <= vel_y_in;
        v_z              <= vel_z_in;
        vel_req          <= 1'b0;
        velocities_ready <= 1'b1;
      end
    end else if (velocities_ready) begin
      if (!request_velocities) begin
        velocities_ready <= 1'b0;
      end
    end else if (request_velocities) begin
      vel_req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sim_sequencer.sv
// Bench for sim_sequencer: reset state, a per-cycle vector table for the
// handshakes, directed multi-cycle corner cases, and randomized traffic
// checked against a behavioural model.
module tb_sim_sequencer;

  localparam int DW = 32;
  localparam int IW = 8;
  localparam int TD = 10;
  localparam int TO = 16;
  localparam int FW = 8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0, step = 1'b0, clear_err = 1'b0;
  logic [IW-1:0] pitch_in = '0, roll_in = '0;
  logic [IW:0]   throttle_in = '0;
  logic          update_enable, update_done = 1'b0;
  logic          request_input = 1'b0, input_ready;
  logic [IW-1:0] pitch_change, roll_change;
  logic [IW:0]   throttle;
  logic          request_velocities = 1'b0, velocities_ready, vel_req, vel_ack = 1'b0;
  logic [DW-1:0] vel_x_in = '0, vel_y_in = '0, vel_z_in = '0;
  logic [DW-1:0] v_x, v_y, v_z;
  logic [FW-1:0] frame_count;
  logic          busy, overrun, timeout_err;

  int n_checks = 0;
  int n_err    = 0;

  sim_sequencer #(
    .DATA_WIDTH (DW), .INPUT_WIDTH (IW), .TICK_DIV (TD), .TIMEOUT (TO), .FRAME_WIDTH (FW)
  ) dut (
    .clk (clk), .reset (reset), .run (run), .step (step), .clear_err (clear_err),
    .pitch_in (pitch_in), .roll_in (roll_in), .throttle_in (throttle_in),
    .update_enable (update_enable), .update_done (update_done),
    .request_input (request_input), .input_ready (input_ready),
    .pitch_change (pitch_change), .roll_change (roll_change), .throttle (throttle),
    .request_velocities (request_velocities), .velocities_ready (velocities_ready),
    .vel_req (vel_req), .vel_ack (vel_ack),
    .vel_x_in (vel_x_in), .vel_y_in (vel_y_in), .vel_z_in (vel_z_in),
    .v_x (v_x), .v_y (v_y), .v_z (v_z),
    .frame_count (frame_count), .busy (busy), .overrun (overrun), .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_update_enable"}, update_enable, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_input_ready"}, input_ready, 1'b0);
    chk1({tag, "_vel_req"}, vel_req, 1'b0);
    chk1({tag, "_vel_ready"}, velocities_ready, 1'b0);
    chk1({tag, "_overrun"}, overrun, 1'b0);
    chk1({tag, "_timeout_err"}, timeout_err, 1'b0);
    chk({tag, "_pitch"}, 32'(pitch_change), 32'h0);
    chk({tag, "_roll"}, 32'(roll_change), 32'h0);
    chk({tag, "_throttle"}, 32'(throttle), 32'h0);
    chk({tag, "_v_x"}, v_x, 32'h0);
    chk({tag, "_v_y"}, v_y, 32'h0);
    chk({tag, "_v_z"}, v_z, 32'h0);
    chk({tag, "_frames"}, 32'(frame_count), 32'h0);
  endtask

  // ---------------- behavioural reference model ----------------
  int            m_phase, m_age, m_frames, m_vph;  // m_vph: 0 none, 1 awaiting ack, 2 ready
  bit            m_busy, m_over, m_tout, m_in_rdy;
  logic [IW-1:0] m_pitch, m_roll;
  logic [IW:0]   m_thr;
  logic [DW-1:0] m_vx, m_vy, m_vz;

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_frames = 0; m_vph = 0;
    m_busy = 0; m_over = 0; m_tout = 0; m_in_rdy = 0;
    m_pitch = '0; m_roll = '0; m_thr = '0; m_vx = '0; m_vy = '0; m_vz = '0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_cycle();
    bit was_busy, tk, finishing, staying, tset;
    was_busy  = m_busy;
    tk        = run && (m_phase == TD - 1);
    m_phase   = run ? (m_phase + 1) % TD : 0;
    finishing = 0;
    tset      = 0;
    if (was_busy) begin
      m_age++;
      if (update_done) begin
        m_frames  = (m_frames + 1) % (1 << FW);
        finishing = 1;
      end else if (m_age >= TO) begin
        tset      = 1;
        finishing = 1;
      end
    end
    staying = was_busy && !finishing;
    if (staying) begin
      if (request_input && !m_in_rdy) begin
        m_pitch = pitch_in; m_roll = roll_in; m_thr = throttle_in;
      end
      m_in_rdy = request_input;
      if (m_vph == 0 && request_velocities) m_vph = 1;
      else if (m_vph == 1 && vel_ack) begin
        m_vx = vel_x_in; m_vy = vel_y_in; m_vz = vel_z_in; m_vph = 2;
      end else if (m_vph == 2 && !request_velocities) m_vph = 0;
    end else begin
      m_in_rdy = 0;
      m_vph    = 0;
    end
    if (tk && was_busy) m_over = 1;
    else if (clear_err) m_over = 0;
    if (tset) m_tout = 1;
    else if (clear_err) m_tout = 0;
    if (!was_busy && (tk || (step && !run))) begin
      m_busy = 1;
      m_age  = 0;
    end else if (finishing) begin
      m_busy = 0;
    end
  endtask

  task automatic chk_model();
    chk1("rnd_update_enable", update_enable, m_busy);
    chk1("rnd_busy", busy, m_busy);
    chk1("rnd_input_ready", input_ready, m_in_rdy);
    chk1("rnd_vel_req", vel_req, m_vph == 1);
    chk1("rnd_vel_ready", velocities_ready, m_vph == 2);
    chk1("rnd_overrun", overrun, m_over);
    chk1("rnd_timeout_err", timeout_err, m_tout);
    chk("rnd_pitch", 32'(pitch_change), 32'(m_pitch));
    chk("rnd_roll", 32'(roll_change), 32'(m_roll));
    chk("rnd_throttle", 32'(throttle), 32'(m_thr));
    chk("rnd_v_x", v_x, m_vx);
    chk("rnd_v_y", v_y, m_vy);
    chk("rnd_v_z", v_z, m_vz);
    chk("rnd_frames", 32'(frame_count), 32'(m_frames));
  endtask

  task automatic do_reset();
    run = 0; step = 0; clear_err = 0; update_done = 0; request_input = 0;
    request_velocities = 0; vel_ack = 0;
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    model_reset();
  endtask

  // Run with periodic ticks, completing each update after `hold` busy cycles;
  // records the observation index and frame_count of each update start.
  task automatic watch(input int hold, input int want, input int budget,
                       output int rise_at[4], output int frm_at[4], output int n);
    int  n_high;
    bit  prev;
    n_high = 0;
    prev   = 0;
    n      = 0;
    for (int i = 0; i < 4; i++) begin rise_at[i] = 0; frm_at[i] = 0; end
    for (int c = 0; c < budget && n < want; c++) begin
      cyc();
      update_done = 1'b0;
      if (update_enable && !prev) begin
        rise_at[n] = c;
        frm_at[n]  = int'(frame_count);
        n++;
        n_high = 0;
      end
      if (update_enable) n_high++;
      if (update_enable && n_high == hold) update_done = 1'b1;
      prev = update_enable;
    end
    update_done = 1'b0;
  endtask

  typedef struct packed {
    logic          step, req_in, req_vel, ack, done;
    logic [7:0]    pitch;
    logic [31:0]   vy;
    logic          e_busy, e_in_rdy, e_vreq, e_vrdy;
    logic [7:0]    e_pitch;
    logic [31:0]   e_vy;
    logic [7:0]    e_frames;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int rise_at[4], frm_at[4], n;

    //           step req_in req_vel ack done pitch  vel_y_in        busy rdy vreq vrdy pitch  v_y           frames
    vecs.push_back(vec_t'{H, L, L, L, L, 8'h00, 32'h0000_0000,   H, L, L, L, 8'h00, 32'h0000_0000, 8'd0});
    vecs.push_back(vec_t'{L, L, L, L, L, 8'hFB, 32'h0000_0000,   H, L, L, L, 8'h00, 32'h0000_0000, 8'd0});
    vecs.push_back(vec_t'{L, H, L, L, L, 8'hFB, 32'h0000_0000,   H, H, L, L, 8'hFB, 32'h0000_0000, 8'd0});
    vecs.push_back(vec_t'{L, H, L, L, L, 8'h22, 32'h0000_0000,   H, H, L, L, 8'hFB, 32'h0000_0000, 8'd0});
    vecs.push_back(vec_t'{L, L, L, L, L, 8'h22, 32'h0000_0000,   H, L, L, L, 8'hFB, 32'h0000_0000, 8'd0});
    vecs.push_back(vec_t'{L, L, H, L, L, 8'h22, 32'hFFFF_0000,   H, L, H, L, 8'hFB, 32'h0000_0000, 8'd0});
    vecs.push_back(vec_t'{L, L, H, L, L, 8'h22, 32'hFFFF_0000,   H, L, H, L, 8'hFB, 32'h0000_0000, 8'd0});
    vecs.push_back(vec_t'{L, L, H, L, L, 8'h22, 32'hFFFF_0000,   H, L, H, L, 8'hFB, 32'h0000_0000, 8'd0});
    vecs.push_back(vec_t'{L, L, H, L, L, 8'h22, 32'hFFFF_0000,   H, L, H, L, 8'hFB, 32'h0000_0000, 8'd0});
    vecs.push_back(vec_t'{L, L, H, H, L, 8'h22, 32'hFFFF_0000,   H, L, L, H, 8'hFB, 32'hFFFF_0000, 8'd0});
    vecs.push_back(vec_t'{L, L, H, L, L, 8'h22, 32'h1234_5678,   H, L, L, H, 8'hFB, 32'hFFFF_0000, 8'd0});
    vecs.push_back(vec_t'{L, L, L, L, L, 8'h22, 32'h1234_5678,   H, L, L, L, 8'hFB, 32'hFFFF_0000, 8'd0});
    vecs.push_back(vec_t'{L, L, L, L, H, 8'h22, 32'h1234_5678,   L, L, L, L, 8'hFB, 32'hFFFF_0000, 8'd1});
    vecs.push_back(vec_t'{H, L, L, L, L, 8'h22, 32'h1234_5678,   H, L, L, L, 8'hFB, 32'hFFFF_0000, 8'd1});
    vecs.push_back(vec_t'{L, L, L, L, H, 8'h22, 32'h1234_5678,   L, L, L, L, 8'hFB, 32'hFFFF_0000, 8'd2});
    vecs.push_back(vec_t'{L, H, L, L, L, 8'h33, 32'h1234_5678,   L, L, L, L, 8'hFB, 32'hFFFF_0000, 8'd2});
    vecs.push_back(vec_t'{L, L, H, H, L, 8'h33, 32'hAAAA_5555,   L, L, L, L, 8'hFB, 32'hFFFF_0000, 8'd2});

    // Reset state.
    do_reset();
    chk_zero("reset");

    // Vector table: input/velocity handshakes, steps, idle requests ignored.
    do_reset();
    foreach (vecs[i]) begin
      step = vecs[i].step; request_input = vecs[i].req_in; request_velocities = vecs[i].req_vel;
      vel_ack = vecs[i].ack; update_done = vecs[i].done; pitch_in = vecs[i].pitch; vel_y_in = vecs[i].vy;
      cyc();
      chk1($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk1($sformatf("vec%0d_update_enable", i), update_enable, vecs[i].e_busy);
      chk1($sformatf("vec%0d_input_ready", i), input_ready, vecs[i].e_in_rdy);
      chk1($sformatf("vec%0d_vel_req", i), vel_req, vecs[i].e_vreq);
      chk1($sformatf("vec%0d_vel_ready", i), velocities_ready, vecs[i].e_vrdy);
      chk($sformatf("vec%0d_pitch", i), 32'(pitch_change), 32'(vecs[i].e_pitch));
      chk($sformatf("vec%0d_v_y", i), v_y, vecs[i].e_vy);
      chk($sformatf("vec%0d_frames", i), 32'(frame_count), 32'(vecs[i].e_frames));
    end
    step = 0; request_input = 0; request_velocities = 0; vel_ack = 0; update_done = 0;

    // Periodic ticks: one update every TD cycles, frames 0,1,2, no overrun.
    do_reset();
    run = 1;
    watch(3, 3, 60, rise_at, frm_at, n);
    chk("tick_rises", 32'(n), 32'd3);
    chk("tick_gap0", 32'(rise_at[1] - rise_at[0]), 32'(TD));
    chk("tick_gap1", 32'(rise_at[2] - rise_at[1]), 32'(TD));
    chk("tick_frame0", 32'(frm_at[0]), 32'd0);
    chk("tick_frame1", 32'(frm_at[1]), 32'd1);
    chk("tick_frame2", 32'(frm_at[2]), 32'd2);
    chk1("tick_overrun", overrun, 1'b0);
    run = 0;

    // Overrun: an update lasting longer than one period drops exactly one tick.
    do_reset();
    run = 1;
    watch(TD + 2, 2, 80, rise_at, frm_at, n);
    chk("ovr_rises", 32'(n), 32'd2);
    chk("ovr_gap", 32'(rise_at[1] - rise_at[0]), 32'(2 * TD));
    chk1("ovr_flag", overrun, 1'b1);
    run = 0;
    clear_err = 1; cyc(); clear_err = 0;
    chk1("ovr_cleared", overrun, 1'b0);

    // Timeout: flag at entry+TO, handshake outputs drop, no frame counted.
    do_reset();
    step = 1; cyc(); step = 0;
    request_input = 1; request_velocities = 1;
    repeat (TO - 1) cyc();
    chk1("to_pre_err", timeout_err, 1'b0);
    chk1("to_pre_busy", busy, 1'b1);
    chk1("to_pre_input_ready", input_ready, 1'b1);
    chk1("to_pre_vel_req", vel_req, 1'b1);
    cyc();
    chk1("to_err", timeout_err, 1'b1);
    chk1("to_busy", busy, 1'b0);
    chk1("to_input_ready", input_ready, 1'b0);
    chk1("to_vel_req", vel_req, 1'b0);
    chk("to_frames", 32'(frame_count), 32'd0);
    request_input = 0; request_velocities = 0;
    clear_err = 1; cyc(); clear_err = 0;
    chk1("to_cleared", timeout_err, 1'b0);

    // Done in the final allowed cycle wins over the timeout.
    step = 1; cyc(); step = 0;
    repeat (TO - 1) cyc();
    update_done = 1; cyc(); update_done = 0;
    chk1("done_vs_to_err", timeout_err, 1'b0);
    chk1("done_vs_to_busy", busy, 1'b0);
    chk("done_vs_to_frames", 32'(frame_count), 32'd1);

    // A timeout and a clear in the same cycle leave the flag set.
    step = 1; cyc(); step = 0;
    repeat (TO - 1) cyc();
    clear_err = 1; cyc(); clear_err = 0;
    chk1("set_beats_clear", timeout_err, 1'b1);

    // frame_count wraps from all ones to zero.
    do_reset();
    for (int i = 0; i < (1 << FW) - 1; i++) begin
      step = 1; cyc(); step = 0;
      update_done = 1; cyc(); update_done = 0;
    end
    chk("wrap_max", 32'(frame_count), 32'((1 << FW) - 1));
    step = 1; cyc(); step = 0;
    update_done = 1; cyc(); update_done = 0;
    chk("wrap_zero", 32'(frame_count), 32'd0);

    // Asynchronous reset in the middle of an update.
    do_reset();
    pitch_in = 8'h7F; vel_y_in = 32'h0000_0055;
    step = 1; cyc(); step = 0;
    request_input = 1; request_velocities = 1; cyc();
    vel_ack = 1; cyc(); vel_ack = 0;
    chk1("pre_rst_busy", busy, 1'b1);
    chk("pre_rst_v_y", v_y, 32'h0000_0055);
    #3 reset = 1;
    #1 chk_zero("async_rst");
    request_input = 0; request_velocities = 0; pitch_in = '0; vel_y_in = '0;
    #2 reset = 0;
    cyc();
    step = 1; cyc(); step = 0;
    chk1("post_rst_busy", busy, 1'b1);
    update_done = 1; cyc(); update_done = 0;
    chk1("post_rst_idle", busy, 1'b0);
    chk("post_rst_frames", 32'(frame_count), 32'd1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 59) == 0) run = ~run;
      step        = ($urandom_range(0, 7) == 0);
      clear_err   = ($urandom_range(0, 15) == 0);
      update_done = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) request_input = ~request_input;
      if ($urandom_range(0, 3) == 0) request_velocities = ~request_velocities;
      vel_ack     = ($urandom_range(0, 2) == 0);
      pitch_in    = 8'($urandom);
      roll_in     = 8'($urandom);
      throttle_in = 9'($urandom_range(0, 100));
      vel_x_in    = $urandom;
      vel_y_in    = $urandom;
      vel_z_in    = $urandom;
      model_cycle();
      cyc();
      chk_model();
      if (c == 1500) begin
        do_reset();
        chk_zero("rnd_reset");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
